// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: shares the sdram_core burst port between two clients.
// One whole burst per grant, round-robin clients, alternating ops, watchdog.
module sdram_burst_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DQ_W        = 16,
    parameter int LEN_W       = 10,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_wr_req,
    input  logic              c0_rd_req,
    input  logic [ADDR_W-1:0] c0_wr_addr,
    input  logic [ADDR_W-1:0] c0_rd_addr,
    input  logic [LEN_W-1:0]  c0_wr_len,
    input  logic [LEN_W-1:0]  c0_rd_len,
    input  logic [DQ_W-1:0]   c0_wr_data,
    output logic              c0_wr_data_req,
    output logic              c0_wr_finish,
    output logic [DQ_W-1:0]   c0_rd_data,
    output logic              c0_rd_data_valid,
    output logic              c0_rd_finish,
    input  logic              c1_wr_req,
    input  logic              c1_rd_req,
    input  logic [ADDR_W-1:0] c1_wr_addr,
    input  logic [ADDR_W-1:0] c1_rd_addr,
    input  logic [LEN_W-1:0]  c1_wr_len,
    input  logic [LEN_W-1:0]  c1_rd_len,
    input  logic [DQ_W-1:0]   c1_wr_data,
    output logic              c1_wr_data_req,
    output logic              c1_wr_finish,
    output logic [DQ_W-1:0]   c1_rd_data,
    output logic              c1_rd_data_valid,
    output logic              c1_rd_finish,
    output logic              wr_burst_req,
    output logic              rd_burst_req,
    output logic [ADDR_W-1:0] wr_burst_addr,
    output logic [ADDR_W-1:0] rd_burst_addr,
    output logic [LEN_W-1:0]  wr_burst_len,
    output logic [LEN_W-1:0]  rd_burst_len,
    output logic [DQ_W-1:0]   wr_burst_data,
    input  logic              wr_burst_data_req,
    input  logic              wr_burst_finish,
    input  logic              rd_burst_data_valid,
    input  logic              rd_burst_finish,
    input  logic [DQ_W-1:0]   rd_burst_data,
    output logic              grant_id,
    output logic              busy,
    output logic              err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t            state;
    logic              op_wr;
    logic              last_client;
    logic [1:0]        last_op;
    logic [CNT_W-1:0]  cnt;
    logic              c0_any;
    logic              c1_any;
    logic              sel_client;
    logic              sel_wr_req;
    logic              sel_rd_req;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              in_issue;
    logic              done;
    logic              tmo;

    // Choose the next client (other than last one) and its op (alternating)
    always_comb begin
        c0_any     = c0_wr_req | c0_rd_req;
        c1_any     = c1_wr_req | c1_rd_req;
        sel_client = (c0_any && c1_any) ? ~last_client : c1_any;
        sel_wr_req = sel_client ? c1_wr_req : c0_wr_req;
        sel_rd_req = sel_client ? c1_rd_req : c0_rd_req;
        sel_wr     = (sel_wr_req && sel_rd_req) ? ~last_op[sel_client]
                                                : sel_wr_req;
        if (sel_client) begin
            sel_addr = sel_wr ? c1_wr_addr : c1_rd_addr;
            sel_len  = sel_wr ? c1_wr_len  : c1_rd_len;
        end else begin
            sel_addr = sel_wr ? c0_wr_addr : c0_rd_addr;
            sel_len  = sel_wr ? c0_wr_len  : c0_rd_len;
        end
    end

    // Route core status to the granted client only, while a burst is live
    always_comb begin
        in_issue         = (state == ISSUE);
        done             = op_wr ? wr_burst_finish : rd_burst_finish;
        tmo              = (cnt == CNT_W'(TIMEOUT_CYC - 1));
        err_timeout      = in_issue && tmo && !done;
        busy             = (state != IDLE);
        c0_wr_data_req   = in_issue && !grant_id && wr_burst_data_req;
        c0_wr_finish     = in_issue && !grant_id && wr_burst_finish;
        c0_rd_data_valid = in_issue && !grant_id && rd_burst_data_valid;
        c0_rd_finish     = in_issue && !grant_id && rd_burst_finish;
        c1_wr_data_req   = in_issue && grant_id && wr_burst_data_req;
        c1_wr_finish     = in_issue && grant_id && wr_burst_finish;
        c1_rd_data_valid = in_issue && grant_id && rd_burst_data_valid;
        c1_rd_finish     = in_issue && grant_id && rd_burst_finish;
        wr_burst_data    = grant_id ? c1_wr_data : c0_wr_data;
        c0_rd_data       = rd_burst_data;
        c1_rd_data       = rd_burst_data;
    end

    // Grant FSM: latch a burst, hold the core request, then force a gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_id      <= 1'b0;
            op_wr         <= 1'b0;
            last_client   <= 1'b1;
            last_op       <= 2'b00;
            cnt           <= '0;
            wr_burst_req  <= 1'b0;
            rd_burst_req  <= 1'b0;
            wr_burst_addr <= '0;
            rd_burst_addr <= '0;
            wr_burst_len  <= '0;
            rd_burst_len  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (c0_any || c1_any) begin
                        grant_id <= sel_client;
                        op_wr    <= sel_wr;
                        cnt      <= '0;
                        state    <= ISSUE;
                        if (sel_wr) begin
                            wr_burst_req  <= 1'b1;
                            wr_burst_addr <= sel_addr;
                            wr_burst_len  <= sel_len;
                        end else begin
                            rd_burst_req  <= 1'b1;
                            rd_burst_addr <= sel_addr;
                            rd_burst_len  <= sel_len;
                        end
                    end
                end
                ISSUE: begin
                    if (done || tmo) begin
                        wr_burst_req      <= 1'b0;
                        rd_burst_req      <= 1'b0;
                        last_client       <= grant_id;
                        last_op[grant_id] <= op_wr;
                        state             <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter: random clients and core against a burst-level
// model; grants are queued by the model and checked by a monitor.
module tb_sdram_burst_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int LW = 10;
    localparam int T  = 8;

    typedef struct {
        logic          cl;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] wr_req = 2'b00;
    logic [1:0] rd_req = 2'b00;
    logic [AW-1:0] wr_addr [2];
    logic [AW-1:0] rd_addr [2];
    logic [LW-1:0] wr_len [2];
    logic [LW-1:0] rd_len [2];
    logic [DW-1:0] wr_data [2];
    logic core_wdreq = 1'b0;
    logic core_wfin = 1'b0;
    logic core_rvalid = 1'b0;
    logic core_rfin = 1'b0;
    logic [DW-1:0] core_rdata = '0;

    logic c0_wr_data_req, c0_wr_finish, c0_rd_data_valid, c0_rd_finish;
    logic c1_wr_data_req, c1_wr_finish, c1_rd_data_valid, c1_rd_finish;
    logic [DW-1:0] c0_rd_data, c1_rd_data, wr_burst_data;
    logic wr_burst_req, rd_burst_req, grant_id, busy, err_timeout;
    logic [AW-1:0] wr_burst_addr, rd_burst_addr;
    logic [LW-1:0] wr_burst_len, rd_burst_len;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_fin = 0;
    int n_tmo = 0;
    logic en = 1'b0;
    logic force_all = 1'b0;
    logic hold = 1'b0;

    exp_t exp_q[$];
    logic m_busy = 1'b0;
    logic m_gap = 1'b0;
    logic m_cl = 1'b0;
    logic m_wr = 1'b0;
    int m_j = 0;
    logic m_last_cl = 1'b1;
    logic [1:0] m_last_op = 2'b00;
    int wr_done [2] = '{0, 0};
    int rd_done [2] = '{0, 0};
    int wr_seen [2] = '{0, 0};
    int rd_seen [2] = '{0, 0};

    sdram_burst_arbiter #(
        .ADDR_W(AW), .DQ_W(DW), .LEN_W(LW), .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_wr_req(wr_req[0]), .c0_rd_req(rd_req[0]),
        .c0_wr_addr(wr_addr[0]), .c0_rd_addr(rd_addr[0]),
        .c0_wr_len(wr_len[0]), .c0_rd_len(rd_len[0]),
        .c0_wr_data(wr_data[0]),
        .c0_wr_data_req(c0_wr_data_req), .c0_wr_finish(c0_wr_finish),
        .c0_rd_data(c0_rd_data), .c0_rd_data_valid(c0_rd_data_valid),
        .c0_rd_finish(c0_rd_finish),
        .c1_wr_req(wr_req[1]), .c1_rd_req(rd_req[1]),
        .c1_wr_addr(wr_addr[1]), .c1_rd_addr(rd_addr[1]),
        .c1_wr_len(wr_len[1]), .c1_rd_len(rd_len[1]),
        .c1_wr_data(wr_data[1]),
        .c1_wr_data_req(c1_wr_data_req), .c1_wr_finish(c1_wr_finish),
        .c1_rd_data(c1_rd_data), .c1_rd_data_valid(c1_rd_data_valid),
        .c1_rd_finish(c1_rd_finish),
        .wr_burst_req(wr_burst_req), .rd_burst_req(rd_burst_req),
        .wr_burst_addr(wr_burst_addr), .rd_burst_addr(rd_burst_addr),
        .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
        .wr_burst_data(wr_burst_data),
        .wr_burst_data_req(core_wdreq), .wr_burst_finish(core_wfin),
        .rd_burst_data_valid(core_rvalid), .rd_burst_finish(core_rfin),
        .rd_burst_data(core_rdata),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, expv);
        end
    endtask

    // Clients: raise random requests, drop each one when its burst ends
    initial begin
        for (int k = 0; k < 2; k++) begin
            wr_addr[k] = '0; rd_addr[k] = '0;
            wr_len[k] = '0; rd_len[k] = '0; wr_data[k] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                wr_data[k] = DW'($urandom);
                if (wr_seen[k] != wr_done[k]) begin
                    wr_seen[k] = wr_done[k];
                    wr_req[k] = 1'b0;
                end else if (!wr_req[k] &&
                    (force_all || (en && $urandom_range(0, 3) == 0))) begin
                    wr_req[k] = 1'b1;
                    wr_addr[k] = AW'($urandom);
                    wr_len[k] = LW'($urandom);
                end
                if (rd_seen[k] != rd_done[k]) begin
                    rd_seen[k] = rd_done[k];
                    rd_req[k] = 1'b0;
                end else if (!rd_req[k] &&
                    (force_all || (en && $urandom_range(0, 3) == 0))) begin
                    rd_req[k] = 1'b1;
                    rd_addr[k] = AW'($urandom);
                    rd_len[k] = LW'($urandom);
                end
            end
        end
    end

    // Core: finish each burst after a random 0..9 cycles, noise otherwise
    initial begin
        automatic logic r_act = 1'b0;
        automatic int r_j = 0;
        automatic int r_len = 0;
        forever begin
            @(posedge clk); #1;
            core_rdata = DW'($urandom);
            if (!rst_n || !(wr_burst_req || rd_burst_req)) begin
                r_act = 1'b0;
                core_wfin = ($urandom_range(0, 7) == 0);
                core_rfin = ($urandom_range(0, 7) == 0);
                core_wdreq = ($urandom_range(0, 1) == 1);
                core_rvalid = ($urandom_range(0, 1) == 1);
            end else begin
                if (!r_act) begin
                    r_act = 1'b1;
                    r_j = 0;
                    r_len = hold ? 1000 : int'($urandom_range(0, 9));
                end else begin
                    r_j++;
                end
                core_wfin = wr_burst_req && (r_j == r_len);
                core_rfin = rd_burst_req && (r_j == r_len);
                core_wdreq = wr_burst_req && ($urandom_range(0, 1) == 1);
                core_rvalid = rd_burst_req && ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Burst-level model: decides grants, ends bursts on finish or watchdog
    initial begin
        automatic logic any0, any1, fin, cl, wr;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_busy = 1'b0; m_gap = 1'b0;
                m_last_cl = 1'b1; m_last_op = 2'b00;
                exp_q.delete();
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_busy) begin
                fin = m_wr ? core_wfin : core_rfin;
                if (fin || m_j == T - 1) begin
                    m_busy = 1'b0; m_gap = 1'b1;
                    if (m_wr) wr_done[m_cl]++;
                    else rd_done[m_cl]++;
                    if (fin) n_fin++;
                    else n_tmo++;
                end else begin
                    m_j++;
                end
            end else begin
                any0 = wr_req[0] | rd_req[0];
                any1 = wr_req[1] | rd_req[1];
                if (any0 || any1) begin
                    if (any0 && any1) cl = !m_last_cl;
                    else cl = any1;
                    if (wr_req[cl] && rd_req[cl]) wr = !m_last_op[cl];
                    else wr = wr_req[cl];
                    m_last_cl = cl;
                    m_last_op[cl] = wr;
                    m_cl = cl; m_wr = wr; m_j = 0; m_busy = 1'b1;
                    exp_q.push_back('{cl, wr,
                        wr ? wr_addr[cl] : rd_addr[cl],
                        wr ? wr_len[cl] : rd_len[cl], cyc});
                end
            end
        end
    end

    // Monitor: pop a grant on each core request rise, check routing each cycle
    initial begin
        automatic logic prev_w = 1'b0;
        automatic logic prev_r = 1'b0;
        automatic logic fin_m;
        automatic logic [3:0] ex0, ex1;
        automatic exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_w = 1'b0; prev_r = 1'b0;
            end else begin
                if ((wr_burst_req && !prev_w) || (rd_burst_req && !prev_r)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("grant", {28'd0, grant_id, wr_burst_req,
                            wr_burst_req ? wr_burst_addr : rd_burst_addr,
                            wr_burst_req ? wr_burst_len : rd_burst_len},
                            {28'd0, e.cl, e.wr, e.addr, e.len});
                        check("grant_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                prev_w = wr_burst_req; prev_r = rd_burst_req;
                fin_m = m_wr ? core_wfin : core_rfin;
                check("core_req", 64'({wr_burst_req, rd_burst_req}),
                      64'({m_busy && m_wr, m_busy && !m_wr}));
                check("busy", 64'(busy), 64'(m_busy || m_gap));
                check("err_timeout", 64'(err_timeout),
                      64'(m_busy && m_j == T - 1 && !fin_m));
                ex0 = (m_busy && !m_cl) ?
                    {core_wdreq, core_wfin, core_rvalid, core_rfin} : 4'b0;
                ex1 = (m_busy && m_cl) ?
                    {core_wdreq, core_wfin, core_rvalid, core_rfin} : 4'b0;
                check("route", 64'({c1_wr_data_req, c1_wr_finish,
                    c1_rd_data_valid, c1_rd_finish, c0_wr_data_req,
                    c0_wr_finish, c0_rd_data_valid, c0_rd_finish}),
                    64'({ex1, ex0}));
                check("rd_data", 64'({c0_rd_data, c1_rd_data}),
                      64'({core_rdata, core_rdata}));
                if (m_busy || m_gap)
                    check("grant_id", 64'(grant_id), 64'(m_cl));
                if (m_busy)
                    check("wr_data", 64'(wr_burst_data), 64'(wr_data[m_cl]));
            end
        end
    end

    // Sequence: reset, random traffic, reset mid-write, drain, summary
    initial begin
        automatic logic found;
        automatic logic pw;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({wr_burst_req, rd_burst_req, grant_id,
            busy, err_timeout, c0_wr_data_req, c0_wr_finish,
            c0_rd_data_valid, c0_rd_finish, c1_wr_data_req, c1_wr_finish,
            c1_rd_data_valid, c1_rd_finish}), 64'(0));
        check("reset_addr", 64'({wr_burst_addr, rd_burst_addr}), 64'(0));
        check("reset_len", 64'({wr_burst_len, rd_burst_len}), 64'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        en = 1'b1;
        repeat (3000) @(posedge clk);
        en = 1'b0;
        force_all = 1'b1;
        hold = 1'b1;
        found = 1'b0;
        pw = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (wr_burst_req && !pw) found = 1'b1;
            pw = wr_burst_req;
        end
        check("wait_wr_burst", 64'(found), 64'(1));
        repeat (2) @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({wr_burst_req, busy, grant_id}), 64'(0));
        repeat (2) @(posedge clk); #3;
        hold = 1'b0;
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wr_burst_req || rd_burst_req) found = 1'b1;
        end
        check("first_after_reset", 64'({found, grant_id, wr_burst_req}),
              64'(3'b101));
        force_all = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("all_idle", 64'({wr_req, rd_req, busy}), 64'(0));
        $display("bursts finished %0d, timed out %0d", n_fin, n_tmo);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
